// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with show-ahead read.
//
// Storage is a DEPTH x DATA_WIDTH register array (DEPTH = 2**ADDR_WIDTH).
// Occupancy is held in an explicit count register. Every status flag is
// decoded from that register alone, so push/pop never reach a flag
// combinationally.
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous active-high reset, highest priority
//   push         write request; w_data is captured when the push is accepted
//   pop          read request; the head advances when the pop is accepted
//   flush        synchronous clear of contents; error flags are untouched
//   clear_err    clears the sticky overflow/underflow flags
//   w_data       push data
//   r_data       head-of-queue data (show-ahead), 0 while empty
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: a push was rejected because the FIFO was full
//   underflow    sticky: a pop was rejected because the FIFO was empty
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic push_acc;
    logic pop_acc;
    logic wr_en;

    // Status flags come only from the registered count.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Show-ahead head data, forced to zero while empty so stale memory never leaks out.
    assign r_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state logic. A pop on a full FIFO frees a slot in the same edge,
    // so a simultaneous push is still accepted. Flush overrides push/pop and
    // suppresses error setting, but clear_err still acts during a flush.
    // A new error wins over a coincident clear_err.
    always_comb begin
        pop_acc     = pop && !empty;
        push_acc    = push && (!full || pop_acc);
        wr_en       = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_en = push_acc;
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && !push_acc) begin
                overflow_d = 1'b1;
            end
            if (pop && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately not reset; the empty gating on r_data hides its contents.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param (default parameters).
// Each scenario task drives its stimulus and compares outputs inline.
module tb_fifo_param;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       flush;
    logic       clear_err;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_LEVEL  (12),
        .AE_LEVEL  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .clear_err   (clear_err),
        .w_data      (w_data),
        .r_data      (r_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; w_data = 8'h00;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_ae got=%b exp=1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_af got=%b exp=0", almost_full); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got=%b%b exp=00", overflow, underflow); end
        checks++; if (r_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=00", r_data); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; w_data = 8'(i);
            tick();
            checks++; if (count !== 5'(i + 1)) begin failures++; $display("[TB] FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            checks++; if (almost_full !== ((i + 1) >= 12)) begin failures++; $display("[TB] FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1) >= 12); end
            checks++; if (almost_empty !== ((i + 1) <= 4)) begin failures++; $display("[TB] FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i + 1) <= 4); end
            checks++; if (full !== ((i + 1) == 16)) begin failures++; $display("[TB] FAIL fill_full[%0d] got=%b exp=%b", i, full, (i + 1) == 16); end
            checks++; if (r_data !== 8'h00) begin failures++; $display("[TB] FAIL fill_rdata[%0d] got=%h exp=00", i, r_data); end
        end
        push = 1'b0;
    endtask

    task automatic test_overflow;
        push = 1'b1; w_data = 8'hAA;
        tick();
        push = 1'b0;
        checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_uflag got=%b exp=0", underflow); end
        checks++; if (r_data !== 8'h00) begin failures++; $display("[TB] FAIL ovf_rdata got=%h exp=00", r_data); end
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL ovf_clear_count got=%0d exp=16", count); end
    endtask

    // Drains the 0x00..0x0F fill; 0xAA must never appear since it was rejected.
    task automatic test_drain;
        for (int i = 0; i < 16; i++) begin
            checks++; if (r_data !== 8'(i)) begin failures++; $display("[TB] FAIL drain_head[%0d] got=%h exp=%h", i, r_data, 8'(i)); end
            pop = 1'b1;
            tick();
            checks++; if (count !== 5'(15 - i)) begin failures++; $display("[TB] FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 15 - i); end
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (r_data !== 8'h00) begin failures++; $display("[TB] FAIL drain_rdata got=%h exp=00", r_data); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL drain_err got=%b%b exp=00", overflow, underflow); end
    endtask

    // 20 pushes and 20 pops with 3 entries in flight, carrying both pointers past the wrap.
    task automatic test_wrap;
        for (int k = 0; k < 3; k++) begin
            push = 1'b1; w_data = 8'(8'h40 + k);
            tick();
        end
        push = 1'b0;
        checks++; if (count !== 5'd3) begin failures++; $display("[TB] FAIL wrap_preload got=%0d exp=3", count); end
        for (int j = 0; j < 17; j++) begin
            checks++; if (r_data !== 8'(8'h40 + j)) begin failures++; $display("[TB] FAIL wrap_head[%0d] got=%h exp=%h", j, r_data, 8'(8'h40 + j)); end
            push = 1'b1; pop = 1'b1; w_data = 8'(8'h40 + j + 3);
            tick();
            checks++; if (count !== 5'd3) begin failures++; $display("[TB] FAIL wrap_count[%0d] got=%0d exp=3", j, count); end
        end
        push = 1'b0;
        for (int j = 17; j < 20; j++) begin
            checks++; if (r_data !== 8'(8'h40 + j)) begin failures++; $display("[TB] FAIL wrap_tail[%0d] got=%h exp=%h", j, r_data, 8'(8'h40 + j)); end
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty got=%b exp=1", empty); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL wrap_err got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_simul_full;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; w_data = 8'(8'h10 + i);
            tick();
        end
        checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL sfull_pre got=%b exp=1", full); end
        push = 1'b1; pop = 1'b1; w_data = 8'h55;
        tick();
        push = 1'b0; pop = 1'b0;
        checks++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL sfull_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL sfull_ovf got=%b exp=0", overflow); end
        checks++; if (r_data !== 8'h11) begin failures++; $display("[TB] FAIL sfull_head got=%h exp=11", r_data); end
        // Expected order after the swap: 0x11..0x1F followed by the appended 0x55.
        for (int i = 0; i < 16; i++) begin
            checks++; if (r_data !== ((i == 15) ? 8'h55 : 8'(8'h11 + i))) begin
                failures++; $display("[TB] FAIL sfull_order[%0d] got=%h exp=%h", i, r_data, (i == 15) ? 8'h55 : 8'(8'h11 + i));
            end
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL sfull_empty got=%b exp=1", empty); end
    endtask

    task automatic test_simul_empty;
        push = 1'b1; pop = 1'b1; w_data = 8'h33;
        tick();
        push = 1'b0; pop = 1'b0;
        checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL sempty_count got=%0d exp=1", count); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL sempty_uf got=%b exp=1", underflow); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL sempty_ovf got=%b exp=0", overflow); end
        checks++; if (r_data !== 8'h33) begin failures++; $display("[TB] FAIL sempty_rdata got=%h exp=33", r_data); end
        pop = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL sempty_drain got=%b exp=1", empty); end
        // Clear coinciding with a fresh underflow: the set wins.
        clear_err = 1'b1;
        tick();
        pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL clr_vs_set got=%b exp=1", underflow); end
        tick();
        clear_err = 1'b0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("[TB] FAIL clr_only got=%b exp=0", underflow); end
        // Re-arm underflow so the flush scenario can confirm it survives.
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL rearm_uf got=%b exp=1", underflow); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 7; i++) begin
            push = 1'b1; w_data = 8'(8'h60 + i);
            tick();
        end
        checks++; if (count !== 5'd7) begin failures++; $display("[TB] FAIL flush_pre got=%0d exp=7", count); end
        flush = 1'b1; push = 1'b1; w_data = 8'h77;
        tick();
        flush = 1'b0; push = 1'b0;
        checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
        checks++; if ({empty, almost_empty} !== 2'b11) begin failures++; $display("[TB] FAIL flush_flags got=%b%b exp=11", empty, almost_empty); end
        checks++; if ({overflow, underflow} !== 2'b01) begin failures++; $display("[TB] FAIL flush_err got=%b%b exp=01", overflow, underflow); end
        checks++; if (r_data !== 8'h00) begin failures++; $display("[TB] FAIL flush_rdata got=%h exp=00", r_data); end
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; w_data = 8'(8'h90 + i);
            tick();
            checks++; if (almost_empty !== ((i + 1) <= 4)) begin failures++; $display("[TB] FAIL flush_ae[%0d] got=%b exp=%b", i, almost_empty, (i + 1) <= 4); end
        end
        push = 1'b0;
        checks++; if (r_data !== 8'h90) begin failures++; $display("[TB] FAIL flush_head got=%h exp=90", r_data); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; w_data = 8'(8'hA0 + i);
            tick();
        end
        push = 1'b0;
        checks++; if (count !== 5'd9) begin failures++; $display("[TB] FAIL rmid_pre got=%0d exp=9", count); end
        rst = 1'b1; push = 1'b1; w_data = 8'hEE;
        tick();
        rst = 1'b0; push = 1'b0;
        checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL rmid_count got=%0d exp=0", count); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            failures++; $display("[TB] FAIL rmid_flags got=%b%b%b%b exp=1010", empty, full, almost_empty, almost_full);
        end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL rmid_err got=%b%b exp=00", overflow, underflow); end
        checks++; if (r_data !== 8'h00) begin failures++; $display("[TB] FAIL rmid_rdata got=%h exp=00", r_data); end
        push = 1'b1; w_data = 8'hC1;
        tick();
        push = 1'b0;
        checks++; if (count !== 5'd1) begin failures++; $display("[TB] FAIL rmid_post_count got=%0d exp=1", count); end
        checks++; if (r_data !== 8'hC1) begin failures++; $display("[TB] FAIL rmid_post_head got=%h exp=c1", r_data); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_simul_full();
        test_simul_empty();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
